m_lsu: RTL and testbench

Memory-stage load/store unit for the pipelined MIPS core. It replaces pure combinational load extension with a handshaked data-memory port of variable latency. The unit generates store byte enables and lane-replicated write data, and sign- or zero-extends load data. It detects misaligned accesses and raises a bus-timeout error. While an access is outstanding, it stalls the pipeline.

---
 rtl/m_lsu_pkg.sv | 42 ++++
 rtl/m_lsu_ext.sv | 38 +++
 rtl/m_lsu.sv | 150 +++++++++++++++
 tb/tb_m_lsu.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/m_lsu_pkg.sv
`default_nettype none
// ============================================================================
// m_lsu_pkg : shared op codes, FSM encodings and decode helpers for m_lsu
// Revision  : 1.0
// ============================================================================
package m_lsu_pkg;

    localparam logic [3:0] c_op_none = 4'd0;
    localparam logic [3:0] c_op_lw   = 4'd1;
    localparam logic [3:0] c_op_lh   = 4'd2;
    localparam logic [3:0] c_op_lhu  = 4'd3;
    localparam logic [3:0] c_op_lb   = 4'd4;
    localparam logic [3:0] c_op_lbu  = 4'd5;
    localparam logic [3:0] c_op_sw   = 4'd6;
    localparam logic [3:0] c_op_sh   = 4'd7;
    localparam logic [3:0] c_op_sb   = 4'd8;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_wait = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    function automatic logic op_is_load(input logic [3:0] op);
        return (op == c_op_lw) || (op == c_op_lh) || (op == c_op_lhu) ||
               (op == c_op_lb) || (op == c_op_lbu);
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        return (op == c_op_sw) || (op == c_op_sh) || (op == c_op_sb);
    endfunction

    function automatic logic op_aligned(input logic [3:0] op, input logic [1:0] lane);
        logic ok;
        ok = 1'b1;
        if ((op == c_op_lw) || (op == c_op_sw))
            ok = (lane == 2'b00);
        else if ((op == c_op_lh) || (op == c_op_lhu) || (op == c_op_sh))
            ok = ~lane[0];
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/m_lsu_ext.sv
`default_nettype none
// ============================================================================
// m_lsu_ext : little-endian load lane select with sign/zero extension
// Revision  : 1.0
// ============================================================================
module m_lsu_ext
    import m_lsu_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [3:0]  op,
    input  logic [1:0]  lane,
    output logic [31:0] data
);

    logic [15:0] w_half;
    logic [7:0]  w_byte;

    always_comb begin
        w_half = lane[1] ? raw[31:16] : raw[15:0];
        case (lane)
            2'd0:    w_byte = raw[7:0];
            2'd1:    w_byte = raw[15:8];
            2'd2:    w_byte = raw[23:16];
            default: w_byte = raw[31:24];
        endcase

        case (op)
            c_op_lw:  data = raw;
            c_op_lh:  data = {{16{w_half[15]}}, w_half};
            c_op_lhu: data = {16'd0, w_half};
            c_op_lb:  data = {{24{w_byte[7]}}, w_byte};
            c_op_lbu: data = {24'd0, w_byte};
            default:  data = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/m_lsu.sv
`default_nettype none
// ============================================================================
// m_lsu    : M-stage load/store unit with handshaked, variable-latency memory
// Revision : 1.0
// ============================================================================
module m_lsu
    import m_lsu_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ls_valid,
    input  logic [3:0]        ls_op,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_stall,
    output logic              ls_done,
    output logic [31:0]       ls_rdata,
    output logic              exc_adel,
    output logic              exc_ades,
    output logic              exc_bus,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    // Counter only has to hold values up to MAX_WAIT-1; timeout fires on the step to MAX_WAIT.
    localparam int              CNT_W      = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_op;
    logic [1:0]       r_lane;
    logic             r_bus_err;

    logic [1:0]  w_lane;
    logic        w_load;
    logic        w_store;
    logic        w_aligned;
    logic        w_idle;
    logic        w_accept;
    logic        w_timeout;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_ext;

    assign w_lane    = ls_addr[1:0];
    assign w_load    = op_is_load(ls_op);
    assign w_store   = op_is_store(ls_op);
    assign w_aligned = op_aligned(ls_op, w_lane);
    assign w_idle    = (r_state == c_st_idle);
    assign w_accept  = w_idle && ls_valid && (w_load || w_store) && w_aligned;
    assign w_timeout = (MAX_WAIT != 0) && (r_cnt == c_cnt_last);

    assign exc_adel = w_idle && ls_valid && w_load  && !w_aligned;
    assign exc_ades = w_idle && ls_valid && w_store && !w_aligned;
    assign ls_stall = w_accept || (r_state == c_st_wait);
    assign ls_done  = (r_state == c_st_done);
    assign exc_bus  = ls_done && r_bus_err;

    always_comb begin
        w_be    = 4'b0000;
        w_wdata = 32'd0;
        case (ls_op)
            c_op_sw: begin
                w_be    = 4'b1111;
                w_wdata = ls_wdata;
            end
            c_op_sh: begin
                w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{ls_wdata[15:0]}};
            end
            c_op_sb: begin
                w_be    = 4'b0001 << w_lane;
                w_wdata = {4{ls_wdata[7:0]}};
            end
            default: ;
        endcase
    end

    m_lsu_ext u_ext (
        .raw  (mem_rdata),
        .op   (r_op),
        .lane (r_lane),
        .data (w_ext)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_st_idle;
            r_cnt     <= '0;
            r_op      <= c_op_none;
            r_lane    <= 2'b00;
            r_bus_err <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'b0000;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
            ls_rdata  <= 32'd0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_cnt     <= '0;
                    r_bus_err <= 1'b0;
                    if (w_accept) begin
                        r_op      <= ls_op;
                        r_lane    <= w_lane;
                        mem_addr  <= {ls_addr[ADDR_W-1:2], 2'b00};
                        mem_we    <= w_store;
                        mem_be    <= w_be;
                        mem_wdata <= w_wdata;
                        mem_req   <= 1'b1;
                        r_state   <= c_st_wait;
                    end
                end
                c_st_wait: begin
                    // A late ack beats a timeout landing in the same cycle.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (op_is_load(r_op))
                            ls_rdata <= w_ext;
                        r_state <= c_st_done;
                    end else if (w_timeout) begin
                        mem_req   <= 1'b0;
                        ls_rdata  <= 32'd0;
                        r_bus_err <= 1'b1;
                        r_state   <= c_st_done;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_st_done: begin
                    r_cnt   <= '0;
                    r_state <= c_st_idle;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_m_lsu.sv
`default_nettype none
// ============================================================================
// tb_m_lsu : directed bench for m_lsu (MAX_WAIT=15 and 0) and m_lsu_ext
// Revision : 1.0
// ============================================================================
module tb_m_lsu;
    import m_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        ls_valid, mem_ack;
    logic [3:0]  ls_op;
    logic [31:0] ls_addr, ls_wdata, mem_rdata;
    logic        ls_stall, ls_done, exc_adel, exc_ades, exc_bus, mem_req, mem_we;
    logic [31:0] ls_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    logic        z_valid, z_ack;
    logic [3:0]  z_op;
    logic [31:0] z_addr, z_wdata, z_mrdata;
    logic        z_stall, z_done, z_adel, z_ades, z_bus, z_req, z_we;
    logic [31:0] z_rdata, z_maddr, z_mwdata;
    logic [3:0]  z_be;

    logic [31:0] ext_raw, ext_data;
    logic [3:0]  ext_op;
    logic [1:0]  ext_lane;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    m_lsu #(.ADDR_W(32), .MAX_WAIT(15)) u_dut (
        .clk(clk), .reset(reset), .ls_valid(ls_valid), .ls_op(ls_op),
        .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_stall(ls_stall),
        .ls_done(ls_done), .ls_rdata(ls_rdata), .exc_adel(exc_adel),
        .exc_ades(exc_ades), .exc_bus(exc_bus), .mem_req(mem_req),
        .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    m_lsu #(.ADDR_W(32), .MAX_WAIT(0)) u_dut0 (
        .clk(clk), .reset(reset), .ls_valid(z_valid), .ls_op(z_op),
        .ls_addr(z_addr), .ls_wdata(z_wdata), .ls_stall(z_stall),
        .ls_done(z_done), .ls_rdata(z_rdata), .exc_adel(z_adel),
        .exc_ades(z_ades), .exc_bus(z_bus), .mem_req(z_req),
        .mem_we(z_we), .mem_be(z_be), .mem_addr(z_maddr),
        .mem_wdata(z_mwdata), .mem_ack(z_ack), .mem_rdata(z_mrdata)
    );

    m_lsu_ext u_ext (.raw(ext_raw), .op(ext_op), .lane(ext_lane), .data(ext_data));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ext_case(input string tag, input logic [3:0] op, input logic [1:0] lane,
                            input logic [31:0] exp);
        ext_op   = op;
        ext_lane = lane;
        #1;
        check(tag, ext_data, exp);
    endtask

    initial begin
        reset    = 1'b1;
        ls_valid = 1'b0; ls_op = c_op_none; ls_addr = '0; ls_wdata = '0;
        mem_ack  = 1'b0; mem_rdata = '0;
        z_valid  = 1'b0; z_op = c_op_none; z_addr = '0; z_wdata = '0;
        z_ack    = 1'b0; z_mrdata = '0;
        ext_raw  = 32'h80FF_1234; ext_op = c_op_none; ext_lane = 2'd0;

        // Stand-alone extender vectors
        ext_case("ext_lw",     c_op_lw,  2'd0, 32'h80FF_1234);
        ext_case("ext_lh_l0",  c_op_lh,  2'd0, 32'h0000_1234);
        ext_case("ext_lh_l2",  c_op_lh,  2'd2, 32'hFFFF_80FF);
        ext_case("ext_lhu_l2", c_op_lhu, 2'd2, 32'h0000_80FF);
        ext_case("ext_lb_l1",  c_op_lb,  2'd1, 32'h0000_0012);
        ext_case("ext_lb_l2",  c_op_lb,  2'd2, 32'hFFFF_FFFF);
        ext_case("ext_lbu_l3", c_op_lbu, 2'd3, 32'h0000_0080);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req",   mem_req,   0);
        check("rst_we",    mem_we,    0);
        check("rst_be",    mem_be,    0);
        check("rst_addr",  mem_addr,  0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_rdata", ls_rdata,  0);
        check("rst_done",  ls_done,   0);
        check("rst_bus",   exc_bus,   0);
        tick(); reset = 1'b0;
        @(negedge clk);
        check("idle_stall", ls_stall, 0);

        // LB at ...03, ack in first WAIT cycle; valid held through DONE must not reissue
        tick(); ls_valid = 1'b1; ls_op = c_op_lb; ls_addr = 32'h0000_1003;
        @(negedge clk);
        check("lb_c0_stall", ls_stall, 1);
        check("lb_c0_req",   mem_req,  0);
        tick(); mem_ack = 1'b1; mem_rdata = 32'h80FF_1234;
        @(negedge clk);
        check("lb_c1_req",   mem_req,  1);
        check("lb_c1_stall", ls_stall, 1);
        check("lb_c1_be",    mem_be,   4'b0000);
        check("lb_c1_we",    mem_we,   0);
        check("lb_c1_addr",  mem_addr, 32'h0000_1000);
        tick(); mem_ack = 1'b0;
        @(negedge clk);
        check("lb_c2_done",  ls_done,  1);
        check("lb_c2_stall", ls_stall, 0);
        check("lb_c2_rdata", ls_rdata, 32'hFFFF_FF80);
        check("lb_c2_bus",   exc_bus,  0);
        tick(); ls_valid = 1'b0;
        @(negedge clk);
        check("lb_c3_noreissue", mem_req, 0);
        check("lb_c3_done",      ls_done, 0);

        // LHU at ...02, ack in cycle 4
        tick(); ls_valid = 1'b1; ls_op = c_op_lhu; ls_addr = 32'h0000_2002;
        @(negedge clk);
        check("lhu_c0_stall", ls_stall, 1);
        for (int c = 1; c <= 4; c++) begin
            tick(); mem_ack = (c == 4);
            @(negedge clk);
            check($sformatf("lhu_c%0d_req", c),  mem_req, 1);
            check($sformatf("lhu_c%0d_done", c), ls_done, 0);
        end
        tick(); mem_ack = 1'b0; ls_valid = 1'b0;
        @(negedge clk);
        check("lhu_c5_done",  ls_done,  1);
        check("lhu_c5_rdata", ls_rdata, 32'h0000_80FF);
        check("lhu_c5_req",   mem_req,  0);

        // SB at ...01
        tick(); ls_valid = 1'b1; ls_op = c_op_sb; ls_addr = 32'h0000_3001; ls_wdata = 32'h0000_00A5;
        @(negedge clk);
        check("sb_c0_stall", ls_stall, 1);
        check("sb_c0_ades",  exc_ades, 0);
        tick(); mem_ack = 1'b1;
        @(negedge clk);
        check("sb_be",    mem_be,    4'b0010);
        check("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
        check("sb_we",    mem_we,    1);
        check("sb_addr",  mem_addr,  32'h0000_3000);
        tick(); mem_ack = 1'b0; ls_valid = 1'b0;
        @(negedge clk);
        check("sb_done", ls_done, 1);

        // SH at ...02 uses the upper half lanes
        tick(); ls_valid = 1'b1; ls_op = c_op_sh; ls_addr = 32'h0000_4002; ls_wdata = 32'h1234_BEEF;
        tick(); mem_ack = 1'b1;
        @(negedge clk);
        check("sh_be",    mem_be,    4'b1100);
        check("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
        tick(); mem_ack = 1'b0; ls_valid = 1'b0;
        @(negedge clk);
        check("sh_done", ls_done, 1);

        // Misaligned SW then LH
        tick(); ls_valid = 1'b1; ls_op = c_op_sw; ls_addr = 32'h0000_5002;
        @(negedge clk);
        check("sw_mis_ades",  exc_ades, 1);
        check("sw_mis_adel",  exc_adel, 0);
        check("sw_mis_stall", ls_stall, 0);
        tick(); ls_op = c_op_lh; ls_addr = 32'h0000_5001;
        @(negedge clk);
        check("sw_mis_noreq", mem_req,  0);
        check("lh_mis_adel",  exc_adel, 1);
        check("lh_mis_ades",  exc_ades, 0);
        check("lh_mis_stall", ls_stall, 0);
        tick(); ls_valid = 1'b0;
        @(negedge clk);
        check("lh_mis_noreq", mem_req,  0);
        check("idle_adel",    exc_adel, 0);

        // LW with no ack: bus error 16 cycles after accept
        tick(); ls_valid = 1'b1; ls_op = c_op_lw; ls_addr = 32'h0000_6000;
        for (int c = 1; c <= 15; c++) begin
            tick();
            @(negedge clk);
            check($sformatf("to_c%0d_req", c),  mem_req, 1);
            check($sformatf("to_c%0d_done", c), ls_done, 0);
        end
        tick();
        @(negedge clk);
        check("to_c16_done",  ls_done,  1);
        check("to_c16_bus",   exc_bus,  1);
        check("to_c16_rdata", ls_rdata, 32'h0);
        check("to_c16_req",   mem_req,  0);
        tick(); ls_valid = 1'b0;
        @(negedge clk);
        check("to_c17_bus",  exc_bus, 0);
        check("to_c17_done", ls_done, 0);

        // Ack arriving on the timeout cycle wins
        tick(); ls_valid = 1'b1; ls_op = c_op_lw; ls_addr = 32'h0000_7000; mem_rdata = 32'hCAFE_F00D;
        for (int c = 1; c <= 15; c++) begin
            tick(); mem_ack = (c == 15);
        end
        tick(); mem_ack = 1'b0; ls_valid = 1'b0;
        @(negedge clk);
        check("ackwin_done",  ls_done,  1);
        check("ackwin_bus",   exc_bus,  0);
        check("ackwin_rdata", ls_rdata, 32'hCAFE_F00D);

        // Reset during the second WAIT cycle
        tick(); ls_valid = 1'b1; ls_op = c_op_lw; ls_addr = 32'h0000_8000;
        tick();
        tick(); reset = 1'b1;
        @(negedge clk);
        check("rw_c2_req", mem_req, 1);
        tick(); reset = 1'b0; ls_valid = 1'b0;
        @(negedge clk);
        check("rw_c3_req",  mem_req, 0);
        check("rw_c3_done", ls_done, 0);
        check("rw_c3_bus",  exc_bus, 0);
        tick();
        @(negedge clk);
        check("rw_c4_done", ls_done, 0);
        tick(); ls_valid = 1'b1; ls_op = c_op_lw; ls_addr = 32'h0000_9004; mem_rdata = 32'h1234_5678;
        tick(); mem_ack = 1'b1;
        @(negedge clk);
        check("rw_lw_req",  mem_req,  1);
        check("rw_lw_addr", mem_addr, 32'h0000_9004);
        tick(); mem_ack = 1'b0; ls_valid = 1'b0;
        @(negedge clk);
        check("rw_lw_done",  ls_done,  1);
        check("rw_lw_rdata", ls_rdata, 32'h1234_5678);

        // MAX_WAIT=0 waits indefinitely
        tick(); z_valid = 1'b1; z_op = c_op_lw; z_addr = 32'h0000_A000; z_mrdata = 32'h0BAD_BEEF;
        for (int c = 1; c <= 40; c++) begin
            tick();
            @(negedge clk);
            check($sformatf("mw0_c%0d_done", c), z_done, 0);
            if (c == 16 || c == 40) begin
                check($sformatf("mw0_c%0d_req", c), z_req, 1);
                check($sformatf("mw0_c%0d_bus", c), z_bus, 0);
            end
        end
        tick(); z_ack = 1'b1;
        tick(); z_ack = 1'b0; z_valid = 1'b0;
        @(negedge clk);
        check("mw0_done",  z_done,  1);
        check("mw0_rdata", z_rdata, 32'h0BAD_BEEF);
        check("mw0_bus",   z_bus,   0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
